fpu_writeback: RTL and testbench

Commit stage of the Bfloat16 FPU. Consumes single-cycle results from the FPU execution stage and writes them back: FP results (16-bit) go to the FP register file, integer-destination results (compares, classify, convert-to-int, moves) go to the shared GPR write port.

- The GPR port is shared with the integer pipe, so it uses a valid/ready handshake backed by a small FIFO.
- The block also owns the sticky accrued exception flags (fflags) and the issue-stall back-pressure signal.

---
 rtl/fpu_wb_pkg.sv | 20 ++
 rtl/fpu_writeback_if.sv | 24 ++
 rtl/fpu_wb_fifo.sv | 50 +++++
 rtl/fpu_writeback.sv | 96 +++++++++
 tb/tb_fpu_writeback.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_wb_pkg.sv
// Shared types and constants for the Bfloat16 FPU writeback stage.
// Flag bit positions follow the {NV,DZ,OF,UF,NX} accrued-exception layout.
package fpu_wb_pkg;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam int WB_XLEN = 32;

   typedef logic [4:0] flags_t;

   typedef struct packed {
      logic [4:0]         addr;
      logic [WB_XLEN-1:0] data;
   } gpr_entry_t;

endpackage

// File: rtl/fpu_writeback_if.sv
// GPR write port shared with the integer pipe: valid/ready handshake.
// The writeback stage is the master; the GPR arbiter is the slave.
interface fpu_writeback_if #(
   parameter int XLEN = 32
);
   logic            gpr_wr_valid;
   logic            gpr_wr_ready;
   logic [4:0]      gpr_waddr;
   logic [XLEN-1:0] gpr_wdata;

   modport master (
      output gpr_wr_valid,
      output gpr_waddr,
      output gpr_wdata,
      input  gpr_wr_ready
   );

   modport slave (
      input  gpr_wr_valid,
      input  gpr_waddr,
      input  gpr_wdata,
      output gpr_wr_ready
   );
endinterface

// File: rtl/fpu_wb_fifo.sv
// Synchronous first-word-fall-through FIFO for integer-destination results.
// Head reads as zero when empty; pointers carry one extra bit to tell full from empty.
module fpu_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (count == (AW+1)'(DEPTH));
   assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fpu_writeback.sv
// Commit stage of the Bfloat16 FPU: FP regfile write, buffered GPR write,
// sticky exception flags and issue back-pressure.
module fpu_writeback
   import fpu_wb_pkg::*;
#(
   parameter int GPR_FIFO_DEPTH = 4,
   parameter int FP_W           = 16,
   parameter int XLEN           = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fpu_complete,
   input  logic [FP_W-1:0]   fpu_result_1,
   input  logic [4:0]        fpu_frd,
   input  logic              fpu_complete_rd,
   input  logic [XLEN-1:0]   fpu_result_rd,
   input  logic [4:0]        fpu_rd,
   input  flags_t            sflags,
   input  logic              IV_exception,
   output logic              frf_we,
   output logic [4:0]        frf_waddr,
   output logic [FP_W-1:0]   frf_wdata,
   fpu_writeback_if.master   gpr,
   output flags_t            fflags,
   input  logic              fflags_wr,
   input  flags_t            fflags_wdata,
   output logic              iv_seen,
   output logic              wb_overflow,
   output logic              fpu_stall,
   output logic              wb_idle
);
   localparam int CW = $clog2(GPR_FIFO_DEPTH) + 1;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [XLEN+4:0]   fifo_head;
   logic              any_complete;

   // Writes to x0 never occupy a FIFO slot.
   assign fifo_push    = fpu_complete_rd && (fpu_rd != 5'd0);
   assign fifo_pop     = gpr.gpr_wr_valid && gpr.gpr_wr_ready;
   assign any_complete = fpu_complete || fpu_complete_rd;

   fpu_wb_fifo #(
      .DEPTH (GPR_FIFO_DEPTH),
      .WIDTH (XLEN + 5)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({fpu_rd, fpu_result_rd}),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign gpr.gpr_wr_valid              = !fifo_empty;
   assign {gpr.gpr_waddr, gpr.gpr_wdata} = fifo_head;

   always_ff @(posedge clk) begin
      if (rst) begin
         frf_we    <= 1'b0;
         frf_waddr <= '0;
         frf_wdata <= '0;
      end else begin
         frf_we <= fpu_complete;
         if (fpu_complete) begin
            frf_waddr <= fpu_frd;
            frf_wdata <= fpu_result_1;
         end
      end
   end

   // A CSR write and a hardware accrual in the same cycle both land.
   always_ff @(posedge clk) begin
      if (rst) begin
         fflags      <= '0;
         iv_seen     <= 1'b0;
         wb_overflow <= 1'b0;
      end else begin
         fflags <= (fflags_wr ? fflags_wdata : fflags) | (any_complete ? sflags : '0);
         if (any_complete && IV_exception)          iv_seen     <= 1'b1;
         if (fifo_push && fifo_full && !fifo_pop)    wb_overflow <= 1'b1;
      end
   end

   // Stalling one entry early leaves room for the op already in flight.
   assign fpu_stall = (fifo_count >= CW'(GPR_FIFO_DEPTH - 1));
   assign wb_idle   = fifo_empty && !frf_we;

endmodule

// File: tb/tb_fpu_writeback.sv
// Directed self-checking bench for fpu_writeback with a GPR-write scoreboard.
module tb_fpu_writeback;
   import fpu_wb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fpu_complete;
   logic [15:0] fpu_result_1;
   logic [4:0]  fpu_frd;
   logic        fpu_complete_rd;
   logic [31:0] fpu_result_rd;
   logic [4:0]  fpu_rd;
   flags_t      sflags;
   logic        IV_exception;
   logic        frf_we;
   logic [4:0]  frf_waddr;
   logic [15:0] frf_wdata;
   flags_t      fflags;
   logic        fflags_wr;
   flags_t      fflags_wdata;
   logic        iv_seen;
   logic        wb_overflow;
   logic        fpu_stall;
   logic        wb_idle;

   fpu_writeback_if #(.XLEN(32)) gpr_if ();

   fpu_writeback #(
      .GPR_FIFO_DEPTH (DEPTH),
      .FP_W           (16),
      .XLEN           (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .fpu_complete    (fpu_complete),
      .fpu_result_1    (fpu_result_1),
      .fpu_frd         (fpu_frd),
      .fpu_complete_rd (fpu_complete_rd),
      .fpu_result_rd   (fpu_result_rd),
      .fpu_rd          (fpu_rd),
      .sflags          (sflags),
      .IV_exception    (IV_exception),
      .frf_we          (frf_we),
      .frf_waddr       (frf_waddr),
      .frf_wdata       (frf_wdata),
      .gpr             (gpr_if),
      .fflags          (fflags),
      .fflags_wr       (fflags_wr),
      .fflags_wdata    (fflags_wdata),
      .iv_seen         (iv_seen),
      .wb_overflow     (wb_overflow),
      .fpu_stall       (fpu_stall),
      .wb_idle         (wb_idle)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   gpr_entry_t exp_q[$];
   logic       exp_ovf = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one integer-destination completion; the scoreboard decides acceptance.
   task automatic push_int(input logic [4:0] rd, input logic [31:0] data);
      gpr_entry_t e;
      fpu_complete_rd = 1'b1;
      fpu_rd          = rd;
      fpu_result_rd   = data;
      e.addr = rd;
      e.data = data;
      if (rd != 5'd0) begin
         if (exp_q.size() < DEPTH || (gpr_if.gpr_wr_ready && exp_q.size() > 0))
            exp_q.push_back(e);
         else
            exp_ovf = 1'b1;
      end
      tick();
      fpu_complete_rd = 1'b0;
   endtask

   task automatic drain(input string tag);
      gpr_if.gpr_wr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_valid_low"}, gpr_if.gpr_wr_valid, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_frf_we"},    frf_we, 1'b0);
      check({tag, "_frf_waddr"}, frf_waddr, 5'd0);
      check({tag, "_frf_wdata"}, frf_wdata, 16'd0);
      check({tag, "_gpr_valid"}, gpr_if.gpr_wr_valid, 1'b0);
      check({tag, "_gpr_waddr"}, gpr_if.gpr_waddr, 5'd0);
      check({tag, "_gpr_wdata"}, gpr_if.gpr_wdata, 32'd0);
      check({tag, "_fflags"},    fflags, 5'd0);
      check({tag, "_iv_seen"},   iv_seen, 1'b0);
      check({tag, "_overflow"},  wb_overflow, 1'b0);
      check({tag, "_stall"},     fpu_stall, 1'b0);
      check({tag, "_idle"},      wb_idle, 1'b1);
   endtask

   // Retirement monitor: a handshake seen at the falling edge pops at the next rising edge.
   logic        hold_prev = 1'b0;
   logic [4:0]  hold_addr;
   logic [31:0] hold_data;

   always @(negedge clk) begin
      if (!rst) begin
         if (gpr_if.gpr_wr_valid && gpr_if.gpr_wr_ready) begin
            check("sb_nonempty_on_pop", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               check("retire_addr", gpr_if.gpr_waddr, exp_q[0].addr);
               check("retire_data", gpr_if.gpr_wdata, exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
         if (gpr_if.gpr_wr_valid && !gpr_if.gpr_wr_ready) begin
            if (hold_prev) begin
               check("hold_addr_stable", gpr_if.gpr_waddr, hold_addr);
               check("hold_data_stable", gpr_if.gpr_wdata, hold_data);
            end
            hold_prev <= 1'b1;
            hold_addr <= gpr_if.gpr_waddr;
            hold_data <= gpr_if.gpr_wdata;
         end else begin
            hold_prev <= 1'b0;
         end
      end else begin
         hold_prev <= 1'b0;
      end
   end

   initial begin
      rst                 = 1'b1;
      fpu_complete        = 1'b0;
      fpu_result_1        = '0;
      fpu_frd             = '0;
      fpu_complete_rd     = 1'b0;
      fpu_result_rd       = '0;
      fpu_rd              = '0;
      sflags              = '0;
      IV_exception        = 1'b0;
      fflags_wr           = 1'b0;
      fflags_wdata        = '0;
      gpr_if.gpr_wr_ready = 1'b0;
      tick();
      tick();
      check_reset_values("reset");
      rst = 1'b0;

      // FP write: one-cycle latency, single-cycle strobe
      fpu_complete = 1'b1;
      fpu_frd      = 5'd7;
      fpu_result_1 = 16'h3F80;
      tick();
      fpu_complete = 1'b0;
      check("fp_we",    frf_we, 1'b1);
      check("fp_waddr", frf_waddr, 5'd7);
      check("fp_wdata", frf_wdata, 16'h3F80);
      check("fp_busy",  wb_idle, 1'b0);
      tick();
      check("fp_we_drop", frf_we, 1'b0);
      check("fp_idle",    wb_idle, 1'b1);

      // Back-pressure: three entries held, then retired in order
      gpr_if.gpr_wr_ready = 1'b0;
      fpu_complete_rd = 1'b1;
      fpu_rd          = 5'd1;
      fpu_result_rd   = 32'h1111_0001;
      #1;
      check("bp_no_same_cycle_valid", gpr_if.gpr_wr_valid, 1'b0);
      push_int(5'd1, 32'h1111_0001);
      check("bp_valid_after_1", gpr_if.gpr_wr_valid, 1'b1);
      check("bp_head_addr_1",   gpr_if.gpr_waddr, 5'd1);
      check("bp_stall_1",       fpu_stall, 1'b0);
      push_int(5'd2, 32'h2222_0002);
      check("bp_stall_2",       fpu_stall, 1'b0);
      push_int(5'd3, 32'h3333_0003);
      check("bp_stall_3",       fpu_stall, 1'b1);
      tick();
      check("bp_head_held",     gpr_if.gpr_waddr, 5'd1);
      gpr_if.gpr_wr_ready = 1'b1;
      tick();
      check("bp_head_2",        gpr_if.gpr_waddr, 5'd2);
      tick();
      check("bp_head_3",        gpr_if.gpr_waddr, 5'd3);
      tick();
      check("bp_drained",       gpr_if.gpr_wr_valid, 1'b0);
      check("bp_idle",          wb_idle, 1'b1);

      // Overflow: fill, push+pop while full, then a dropped push
      gpr_if.gpr_wr_ready = 1'b0;
      push_int(5'd4, 32'hA000_0004);
      push_int(5'd5, 32'hA000_0005);
      push_int(5'd6, 32'hA000_0006);
      push_int(5'd7, 32'hA000_0007);
      check("ovf_full_stall",  fpu_stall, 1'b1);
      check("ovf_none_yet",    wb_overflow, 1'b0);
      gpr_if.gpr_wr_ready = 1'b1;
      push_int(5'd9, 32'hA000_0009);
      gpr_if.gpr_wr_ready = 1'b0;
      check("ovf_pushpop_flag", wb_overflow, exp_ovf);
      check("ovf_pushpop_head", gpr_if.gpr_waddr, 5'd5);
      check("ovf_pushpop_stall", fpu_stall, 1'b1);
      push_int(5'd10, 32'hA000_000A);
      check("ovf_dropped_flag", wb_overflow, exp_ovf);
      check("ovf_dropped_set",  wb_overflow, 1'b1);
      drain("ovf");
      check("ovf_sticky",       wb_overflow, 1'b1);

      // x0 discard: nothing queued, flags still accrue
      sflags = 5'b00001;
      push_int(5'd0, 32'hDEAD_BEEF);
      sflags = '0;
      check("x0_no_valid",   gpr_if.gpr_wr_valid, 1'b0);
      check("x0_fflags",     fflags, 5'b00001);
      check("x0_nx_bit",     fflags[FLAG_NX], 1'b1);

      // Flag race: CSR write and accrual in the same cycle both land
      fflags_wr    = 1'b1;
      fflags_wdata = 5'b10000;
      tick();
      fflags_wr    = 1'b0;
      check("csr_write",     fflags, 5'b10000);
      check("iv_before",     iv_seen, 1'b0);
      fflags_wr    = 1'b1;
      fflags_wdata = 5'b00000;
      fpu_complete = 1'b1;
      fpu_frd      = 5'd3;
      fpu_result_1 = 16'hC000;
      sflags       = 5'b00100;
      IV_exception = 1'b1;
      tick();
      fflags_wr    = 1'b0;
      fpu_complete = 1'b0;
      sflags       = '0;
      IV_exception = 1'b0;
      check("race_fflags",   fflags, 5'b00100);
      check("race_iv_seen",  iv_seen, 1'b1);
      check("race_fp_addr",  frf_waddr, 5'd3);
      tick();
      check("fflags_sticky", fflags, 5'b00100);
      check("iv_sticky",     iv_seen, 1'b1);
      gpr_if.gpr_wr_ready = 1'b1;
      sflags = 5'b01000;
      push_int(5'd5, 32'h0000_0055);
      sflags = '0;
      check("accrue_or",     fflags, 5'b01100);
      check("accrue_dz_bit", fflags[FLAG_DZ], 1'b1);
      drain("accrue");

      // Reset mid-operation: pending entries and FP write are discarded
      gpr_if.gpr_wr_ready = 1'b0;
      push_int(5'd10, 32'hB000_000A);
      push_int(5'd11, 32'hB000_000B);
      check("mid_pending_valid", gpr_if.gpr_wr_valid, 1'b1);
      check("mid_pending_head",  gpr_if.gpr_waddr, 5'd10);
      rst          = 1'b1;
      fpu_complete = 1'b1;
      fpu_frd      = 5'd9;
      fpu_result_1 = 16'h4040;
      exp_q.delete();
      exp_ovf = 1'b0;
      tick();
      rst          = 1'b0;
      fpu_complete = 1'b0;
      check_reset_values("midrst");
      tick();
      check("midrst_idle_after", wb_idle, 1'b1);
      check("midrst_no_valid",   gpr_if.gpr_wr_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
